asteroid_ground_monitor: RTL and testbench
==========================================

// Module: asteroid_ground_monitor
// PURPOSE
//  Multi-channel, parametrised asteroid/ground collision checker with a lives counter.
//  Once per frame, on the asteroid_move_done strobe, it snapshots NUM_AST asteroid heights.
//  It scans them one channel per cycle and flags each asteroid that reached the ground.
//  It charges one life per hit and raises gameover when lives are exhausted.
//  Sits between the asteroid mover and the game-control FSM/score display.
// PARAMETERS
//  NUM_AST   4    number of asteroid channels (>=1)
//  Y_WIDTH   7    bit width of each asteroid y coordinate
//  GROUND_Y  100  y at/after which an asteroid counts as hitting the ground (y >= GROUND_Y)
//  LIVES     3    lives granted on start (1..2**LIVES_W-1)
//  LIVES_W   2    width of lives_left
// PORTS
//  clock               in   1                  system clock, rising edge
//  reset               in   1                  asynchronous, active-high
//  start               in   1                  level; arms block from S_WAIT, restarts from S_OVER
//  asteroid_move_done  in   1                  1-cycle frame strobe from asteroid mover
//  ast_valid           in   NUM_AST            per-channel asteroid-alive flags
//  ast_y               in   NUM_AST*Y_WIDTH    packed y coords, channel i at [i*Y_WIDTH +: Y_WIDTH]
//  ground_hit          out  NUM_AST            per-channel hit flags for the last completed scan
//  lives_left          out  LIVES_W            remaining lives
//  scan_done           out  1                  1-cycle pulse: frame scan finished, outputs updated
//  busy                out  1                  high in S_SCAN and S_APPLY
//  overrun             out  1                  sticky: strobe arrived while busy
//  gameover            out  1                  high while in S_OVER
// BEHAVIOUR
//  Reset values (asynchronous): state=S_WAIT; ground_hit=0; lives_left=LIVES; scan_done=0;
//   busy=0; overrun=0; gameover=0; idx=0; hit_cnt=0.
//  FSM (all transitions on rising clock):
//   S_WAIT : start=1 -> S_ARMED; lives_left<=LIVES; overrun<=0.
//   S_ARMED: asteroid_move_done=1 -> S_SCAN; snapshot ast_valid/ast_y; idx<=0; hit_cnt<=0;
//            ground_hit<=0.
//   S_SCAN : checks snapshot channel idx; sets ground_hit[idx] if valid && y>=GROUND_Y
//            (unsigned compare) and increments hit_cnt (width clog2(NUM_AST+1), no overflow).
//            idx==NUM_AST-1 -> S_APPLY, else idx+1.
//   S_APPLY: lives_left <= lives_left - min(hit_cnt, lives_left); never wraps below 0.
//            Result 0 -> S_OVER, gameover<=1. Otherwise -> S_ARMED with scan_done=1 for 1 cycle.
//   S_OVER : ground_hit and lives_left hold; gameover=1. start=1 -> S_ARMED; gameover<=0;
//            lives_left<=LIVES; ground_hit<=0; overrun<=0.
//  Latency: strobe sampled at edge k -> last channel checked at edge k+NUM_AST ->
//   lives/gameover updated at edge k+NUM_AST+1. scan_done high during the following cycle.
//   No scan_done pulse on the game-ending frame; gameover rises instead.
//  Strobe in S_SCAN/S_APPLY: ignored and sets overrun. Strobe in S_WAIT/S_OVER: ignored, no flag.
//  Snapshot isolation: changes to ast_* during a scan do not affect that scan.
//  start in S_ARMED/S_SCAN/S_APPLY: ignored.
//  Invalid channels never hit, whatever their y.
//  Reset asserted mid-scan forces reset values immediately. No partial life deduction survives.
//  Unused state encodings -> S_WAIT.
// TESTING
//  1 reset, start, strobe with all valid=0 -> scan_done at k+NUM_AST+2; ground_hit=0; lives=3.
//  2 NUM_AST=4, ch1 y=100, ch3 y=120, ch0 y=99, all valid -> ground_hit=4'b1010;
//    lives 3->1; scan_done pulses.
//  3 lives=1, two hits in one frame -> lives=0 (no wrap), gameover=1, no scan_done.
//    Then start -> lives=3, gameover=0.
//  4 second strobe 2 cycles after the first -> overrun=1; only one deduction; ast_y changed
//    mid-scan has no effect.
//  5 ch2 y=127, valid=0 -> no hit.
//  6 reset pulsed during S_SCAN -> all outputs at reset values within the same cycle.
//    Strobe before start ignored.

Source files
------------

// File: rtl/asteroid_ground_monitor.sv
// Per-frame asteroid/ground collision scanner with a lives counter.
// Snapshots all channels on the frame strobe, scans one per cycle, then charges lives.
module asteroid_ground_monitor #(
  parameter int          NUM_AST  = 4,
  parameter int          Y_WIDTH  = 7,
  parameter int unsigned GROUND_Y = 100,
  parameter int          LIVES    = 3,
  parameter int          LIVES_W  = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       asteroid_move_done,
  input  logic [NUM_AST-1:0]         ast_valid,
  input  logic [NUM_AST*Y_WIDTH-1:0] ast_y,
  output logic [NUM_AST-1:0]         ground_hit,
  output logic [LIVES_W-1:0]         lives_left,
  output logic                       scan_done,
  output logic                       busy,
  output logic                       overrun,
  output logic                       gameover
);

  localparam int CW = $clog2(NUM_AST + 1);
  localparam int IW = (NUM_AST > 1) ? $clog2(NUM_AST) : 1;
  localparam int DW = (CW > LIVES_W) ? CW : LIVES_W;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_ARMED = 3'd1,
    S_SCAN  = 3'd2,
    S_APPLY = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t                     state;
  state_t                     state_n;
  logic [IW-1:0]              idx;
  logic [CW-1:0]              hit_cnt;
  logic [NUM_AST-1:0]         snap_valid;
  logic [NUM_AST*Y_WIDTH-1:0] snap_y;
  logic [Y_WIDTH-1:0]         cur_y;
  logic                       cur_hit;
  logic                       last;
  logic [DW-1:0]              hits_x;
  logic [DW-1:0]              lives_x;
  logic [LIVES_W-1:0]         lives_next;

  assign cur_y   = snap_y[32'(idx)*Y_WIDTH +: Y_WIDTH];
  assign cur_hit = snap_valid[idx] && (32'(cur_y) >= GROUND_Y);
  assign last    = (idx == IW'(NUM_AST - 1));
  assign busy    = (state == S_SCAN) || (state == S_APPLY);

  // Saturating deduction: a frame can never take more lives than remain.
  always_comb begin
    hits_x  = DW'(hit_cnt);
    lives_x = DW'(lives_left);
    if (hits_x >= lives_x) begin
      lives_next = '0;
    end else begin
      lives_next = LIVES_W'(lives_x - hits_x);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_WAIT:  if (start) state_n = S_ARMED;
      S_ARMED: if (asteroid_move_done) state_n = S_SCAN;
      S_SCAN:  if (last) state_n = S_APPLY;
      S_APPLY: state_n = (lives_next == '0) ? S_OVER : S_ARMED;
      S_OVER:  if (start) state_n = S_ARMED;
      default: state_n = S_WAIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_WAIT;
      ground_hit <= '0;
      lives_left <= LIVES_W'(LIVES);
      scan_done  <= 1'b0;
      overrun    <= 1'b0;
      gameover   <= 1'b0;
      idx        <= '0;
      hit_cnt    <= '0;
      snap_valid <= '0;
      snap_y     <= '0;
    end else begin
      state     <= state_n;
      scan_done <= 1'b0;
      if (busy && asteroid_move_done) overrun <= 1'b1;
      case (state)
        S_WAIT: begin
          if (start) begin
            lives_left <= LIVES_W'(LIVES);
            overrun    <= 1'b0;
          end
        end
        S_ARMED: begin
          if (asteroid_move_done) begin
            snap_valid <= ast_valid;
            snap_y     <= ast_y;
            idx        <= '0;
            hit_cnt    <= '0;
            ground_hit <= '0;
          end
        end
        S_SCAN: begin
          if (cur_hit) begin
            ground_hit[idx] <= 1'b1;
            hit_cnt         <= hit_cnt + CW'(1);
          end
          if (!last) idx <= idx + IW'(1);
        end
        S_APPLY: begin
          lives_left <= lives_next;
          if (lives_next == '0) gameover  <= 1'b1;
          else                  scan_done <= 1'b1;
        end
        S_OVER: begin
          if (start) begin
            gameover   <= 1'b0;
            lives_left <= LIVES_W'(LIVES);
            ground_hit <= '0;
            overrun    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_asteroid_ground_monitor.sv
// Randomized self-checking bench for asteroid_ground_monitor.
// Reference model: per-frame hit set and saturating lives arithmetic.
module tb_asteroid_ground_monitor;

  localparam int N  = 4;
  localparam int YW = 7;

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic            strobe;
  logic [N-1:0]    ast_valid;
  logic [N*YW-1:0] ast_y;
  logic [N-1:0]    ground_hit;
  logic [1:0]      lives_left;
  logic            scan_done;
  logic            busy;
  logic            overrun;
  logic            gameover;

  int n_tests = 0;
  int n_fail  = 0;
  int m_lives;
  bit m_over;
  bit m_overrun;

  asteroid_ground_monitor dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .asteroid_move_done (strobe),
    .ast_valid          (ast_valid),
    .ast_y              (ast_y),
    .ground_hit         (ground_hit),
    .lives_left         (lives_left),
    .scan_done          (scan_done),
    .busy               (busy),
    .overrun            (overrun),
    .gameover           (gameover)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_lives   = 3;
    m_over    = 1'b0;
    m_overrun = 1'b0;
  endtask

  task automatic run_frame(input logic [N-1:0] v, input logic [N*YW-1:0] y,
                           input bit dbl, input string tag);
    logic [N-1:0]  e_hit;
    logic [YW-1:0] yy;
    int cnt;
    int e_lives;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      yy = y[i*YW +: YW];
      e_hit[i] = v[i] && (int'(yy) >= 100);
      if (e_hit[i]) cnt++;
    end
    e_lives = (cnt >= m_lives) ? 0 : m_lives - cnt;
    if (dbl) m_overrun = 1'b1;
    ast_valid = v;
    ast_y     = y;
    strobe    = 1'b1;
    tick();
    for (int c = 1; c <= N; c++) begin
      ast_valid = N'($urandom);
      ast_y     = (N*YW)'($urandom);
      strobe    = (dbl && c == 2);
      n_tests++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy c%0d: got %b want 1", tag, c, busy);
      end
      tick();
    end
    strobe = 1'b0;
    n_tests++;
    if (scan_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s early_done: got %b want 0", tag, scan_done);
    end
    tick();
    n_tests++;
    if (ground_hit !== e_hit) begin
      n_fail++;
      $display("FAIL %s ground_hit: got %b want %b", tag, ground_hit, e_hit);
    end
    n_tests++;
    if (lives_left !== 2'(e_lives)) begin
      n_fail++;
      $display("FAIL %s lives: got %0d want %0d", tag, lives_left, e_lives);
    end
    n_tests++;
    if (gameover !== (e_lives == 0)) begin
      n_fail++;
      $display("FAIL %s gameover: got %b want %b", tag, gameover, e_lives == 0);
    end
    n_tests++;
    if (scan_done !== (e_lives != 0)) begin
      n_fail++;
      $display("FAIL %s scan_done: got %b want %b", tag, scan_done, e_lives != 0);
    end
    n_tests++;
    if (overrun !== m_overrun || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s overrun/busy: got %b%b want %b0", tag, overrun, busy, m_overrun);
    end
    tick();
    n_tests++;
    if (scan_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_width: got %b want 0", tag, scan_done);
    end
    m_lives = e_lives;
    m_over  = (e_lives == 0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    strobe = 1'b0;
    ast_valid = '0;
    ast_y = '0;
    tick();
    tick();
    n_tests++;
    if ({ground_hit, lives_left, scan_done, busy, overrun, gameover} !== 10'b0000_11_0000) begin
      n_fail++;
      $display("FAIL reset: got hit=%b lives=%0d d/b/o/g=%b%b%b%b want 0 3 0000",
               ground_hit, lives_left, scan_done, busy, overrun, gameover);
    end
    reset = 1'b0;
    tick();
    m_lives = 3;
    m_over = 1'b0;
    m_overrun = 1'b0;
  endtask

  task automatic test_strobe_before_start(input string tag);
    strobe = 1'b1;
    ast_valid = '1;
    ast_y = '1;
    tick();
    strobe = 1'b0;
    for (int c = 0; c < N + 3; c++) begin
      n_tests++;
      if (busy !== 1'b0 || scan_done !== 1'b0 || overrun !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle c%0d: got b/d/o=%b%b%b want 000", tag, c, busy, scan_done, overrun);
      end
      tick();
    end
  endtask

  task automatic test_empty;
    do_start();
    run_frame('0, '1, 1'b0, "empty");
  endtask

  task automatic test_directed;
    logic [N*YW-1:0] y;
    y = {7'd120, 7'd50, 7'd100, 7'd99};
    run_frame(4'hF, y, 1'b0, "directed");
    n_tests++;
    if (ground_hit !== 4'b1010 || lives_left !== 2'd1) begin
      n_fail++;
      $display("FAIL directed_abs: got %b/%0d want 1010/1", ground_hit, lives_left);
    end
  endtask

  task automatic test_gameover;
    logic [N*YW-1:0] y;
    y = {7'd10, 7'd20, 7'd127, 7'd110};
    run_frame(4'hF, y, 1'b0, "gameover");
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    tick();
    n_tests++;
    if (gameover !== 1'b1 || lives_left !== 2'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL over_hold: got g/l/b/o=%b/%0d/%b/%b want 1/0/0/0",
               gameover, lives_left, busy, overrun);
    end
    do_start();
    n_tests++;
    if (gameover !== 1'b0 || lives_left !== 2'd3 || ground_hit !== '0) begin
      n_fail++;
      $display("FAIL restart: got g/l/h=%b/%0d/%b want 0/3/0000", gameover, lives_left, ground_hit);
    end
  endtask

  task automatic test_overrun;
    logic [N*YW-1:0] y;
    y = {7'd10, 7'd105, 7'd20, 7'd30};
    run_frame(4'hF, y, 1'b1, "overrun");
  endtask

  task automatic test_invalid;
    logic [N*YW-1:0] y;
    y = {7'd99, 7'd127, 7'd5, 7'd0};
    run_frame(4'b1011, y, 1'b0, "invalid");
  endtask

  task automatic test_reset_mid_scan;
    ast_valid = '1;
    ast_y = '1;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({ground_hit, lives_left, scan_done, busy, overrun, gameover} !== 10'b0000_11_0000) begin
      n_fail++;
      $display("FAIL mid_reset: got hit=%b lives=%0d d/b/o/g=%b%b%b%b want 0 3 0000",
               ground_hit, lives_left, scan_done, busy, overrun, gameover);
    end
    tick();
    reset = 1'b0;
    m_lives = 3;
    m_over = 1'b0;
    m_overrun = 1'b0;
    test_strobe_before_start("post_reset");
    do_start();
  endtask

  task automatic test_random;
    logic [N-1:0]    v;
    logic [N*YW-1:0] y;
    for (int f = 0; f < 60; f++) begin
      if (m_over) do_start();
      v = N'($urandom);
      for (int i = 0; i < N; i++) y[i*YW +: YW] = YW'($urandom_range(70, 127));
      run_frame(v, y, ($urandom_range(0, 7) == 0), "random");
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_strobe_before_start("pre_start");
    test_empty();
    test_directed();
    test_gameover();
    test_overrun();
    test_invalid();
    run_frame(4'h1, {7'd0, 7'd0, 7'd0, 7'd100}, 1'b0, "one_hit");
    test_reset_mid_scan();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
